// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared mem_system port between instruction fetch and data access.
// Data has priority; a starvation counter bounds fetch latency and a watchdog aborts hung transactions.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        d_hit,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_rdata,
    input  logic        m_done,
    input  logic        m_hit,
    input  logic        m_err,
    output logic [1:0]  owner,
    output logic        err
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } state_t;

    state_t      state;
    logic [3:0]  starve_cnt;
    logic [7:0]  wd_cnt;
    logic [15:0] l_addr;
    logic [15:0] l_wdata;
    logic        l_rd;
    logic        l_wr;

    logic d_req;
    logic data_win;
    logic fetch_win;
    logic grant;
    logic busy;
    logic wd_exp;
    logic illegal;

    // Grants are gated by reset so nothing reaches mem_system while rst is held low.
    assign d_req     = d_rd | d_wr;
    assign data_win  = rst & d_req & ~(i_req & (starve_cnt == STARVE_MAX));
    assign fetch_win = rst & ~data_win & i_req;
    assign grant     = data_win | fetch_win;
    assign busy      = (state != IDLE);
    assign wd_exp    = busy & (wd_cnt == WD_LAST) & ~m_done;
    assign illegal   = (state == IDLE) & data_win & d_rd & d_wr;

    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        i_done  = 1'b0;
        d_done  = 1'b0;
        case (state)
            IDLE: begin
                if (data_win) begin
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                    m_wr    = d_wr;
                    m_rd    = d_rd & ~d_wr;
                    d_done  = m_done;
                end else if (fetch_win) begin
                    m_addr = i_addr;
                    m_rd   = 1'b1;
                    i_done = m_done;
                end
            end
            BUSY_I, BUSY_D: begin
                m_addr  = l_addr;
                m_wdata = l_wdata;
                m_rd    = l_rd;
                m_wr    = l_wr;
                i_done  = (state == BUSY_I) & (m_done | wd_exp);
                d_done  = (state == BUSY_D) & (m_done | wd_exp);
            end
            default: ;
        endcase
    end

    assign i_data  = (i_done & ~wd_exp) ? m_rdata : '0;
    assign d_rdata = (d_done & ~wd_exp) ? m_rdata : '0;
    assign d_hit   = d_done & m_hit;
    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 2'b00;
            starve_cnt <= '0;
            wd_cnt     <= '0;
            err        <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_rd       <= 1'b0;
            l_wr       <= 1'b0;
        end else begin
            if (m_err || illegal || wd_exp)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (grant) begin
                        if (data_win && i_req)
                            starve_cnt <= (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 4'd1;
                        else
                            starve_cnt <= '0;
                        if (!m_done) begin
                            // Capture the values already on m_* so the busy phase replays them exactly.
                            l_addr  <= m_addr;
                            l_wdata <= m_wdata;
                            l_rd    <= m_rd;
                            l_wr    <= m_wr;
                            state   <= data_win ? BUSY_D : BUSY_I;
                            owner   <= data_win ? 2'b10 : 2'b01;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (m_done || wd_exp) begin
                        state  <= IDLE;
                        owner  <= 2'b00;
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays the mem_system side by hand.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic        i_done;
    logic        i_stall;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        d_hit;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_rd;
    logic        m_wr;
    logic [15:0] m_rdata;
    logic        m_done;
    logic        m_hit;
    logic        m_err;
    logic [1:0]  owner;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_done(i_done), .i_stall(i_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall), .d_hit(d_hit),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
        .m_rdata(m_rdata), .m_done(m_done), .m_hit(m_hit), .m_err(m_err),
        .owner(owner), .err(err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; i_req = 0; i_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        m_rdata = '0; m_done = 0; m_hit = 0; m_err = 0;
        tick(); tick();
        chk("rst_owner", 16'(owner), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_m_rd", 16'(m_rd), 16'd0);
        chk("rst_i_done", 16'(i_done), 16'd0);

        // Fetch-only hit
        rst = 1'b1;
        tick();
        i_req = 1; i_addr = 16'h0040; m_done = 1; m_rdata = 16'hA5A5;
        #1;
        chk("fh_m_rd", 16'(m_rd), 16'd1);
        chk("fh_m_addr", m_addr, 16'h0040);
        chk("fh_i_done", 16'(i_done), 16'd1);
        chk("fh_i_data", i_data, 16'hA5A5);
        chk("fh_i_stall", 16'(i_stall), 16'd0);
        chk("fh_owner", 16'(owner), 16'd0);
        tick();
        i_req = 0; m_done = 0; m_rdata = '0;
        #1;
        chk("fh_owner_after", 16'(owner), 16'd0);
        chk("fh_i_done_after", 16'(i_done), 16'd0);

        // Data read miss, done in the fifth cycle
        d_rd = 1; d_addr = 16'h1238;
        #1;
        chk("dr_m_rd0", 16'(m_rd), 16'd1);
        chk("dr_m_addr0", m_addr, 16'h1238);
        chk("dr_d_done0", 16'(d_done), 16'd0);
        chk("dr_d_stall0", 16'(d_stall), 16'd1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) d_addr = 16'h0000;
            if (c == 4) begin m_done = 1; m_rdata = 16'hBEEF; m_hit = 0; end
            #1;
            chk("dr_owner", 16'(owner), 16'd2);
            chk("dr_m_rd", 16'(m_rd), 16'd1);
            chk("dr_m_addr", m_addr, 16'h1238);
            chk("dr_d_done", 16'(d_done), (c == 4) ? 16'd1 : 16'd0);
            chk("dr_d_rdata", d_rdata, (c == 4) ? 16'hBEEF : 16'h0000);
            chk("dr_i_done", 16'(i_done), 16'd0);
        end
        tick();
        d_rd = 0; m_done = 0; m_rdata = '0;
        #1;
        chk("dr_owner_end", 16'(owner), 16'd0);
        chk("dr_d_done_end", 16'(d_done), 16'd0);
        chk("dr_m_rd_end", 16'(m_rd), 16'd0);

        // Contention: four data grants, one fetch, then data again
        i_req = 1; i_addr = 16'h0100; d_wr = 1; d_addr = 16'h2000; d_wdata = 16'h1234;
        for (int t = 0; t < 6; t++) begin
            logic exp_d;
            exp_d = (t != 4);
            #1;
            chk("ct_m_wr", 16'(m_wr), 16'(exp_d));
            chk("ct_m_rd", 16'(m_rd), 16'(!exp_d));
            chk("ct_m_addr", m_addr, exp_d ? 16'h2000 : 16'h0100);
            chk("ct_m_wdata", m_wdata, exp_d ? 16'h1234 : 16'h0000);
            tick();
            chk("ct_owner", 16'(owner), exp_d ? 16'd2 : 16'd1);
            tick();
            m_done = 1;
            #1;
            chk("ct_d_done", 16'(d_done), 16'(exp_d));
            chk("ct_i_done", 16'(i_done), 16'(!exp_d));
            tick();
            m_done = 0;
        end
        i_req = 0; d_wr = 0; d_wdata = '0;
        tick();

        // Watchdog expiry
        d_rd = 1; d_addr = 16'h3000; m_rdata = 16'hFFFF;
        #1;
        chk("wd_err_before", 16'(err), 16'd0);
        for (int b = 0; b < 64; b++) begin
            tick();
            chk("wd_d_done", 16'(d_done), (b == 63) ? 16'd1 : 16'd0);
            if (b == 63) chk("wd_d_rdata", d_rdata, 16'h0000);
        end
        tick();
        chk("wd_err", 16'(err), 16'd1);
        chk("wd_owner", 16'(owner), 16'd0);
        m_done = 1;
        #1;
        chk("wd_next_done", 16'(d_done), 16'd1);
        chk("wd_next_rdata", d_rdata, 16'hFFFF);
        tick();
        d_rd = 0; m_done = 0; m_rdata = '0;
        tick();
        chk("wd_err_sticky", 16'(err), 16'd1);

        // Illegal op: read and write together behave as a write and flag err
        rst = 0;
        tick();
        rst = 1;
        #1;
        chk("il_err_cleared", 16'(err), 16'd0);
        d_rd = 1; d_wr = 1; d_addr = 16'h4000; m_done = 1;
        #1;
        chk("il_m_wr", 16'(m_wr), 16'd1);
        chk("il_m_rd", 16'(m_rd), 16'd0);
        tick();
        d_rd = 0; d_wr = 0; m_done = 0;
        #1;
        chk("il_err", 16'(err), 16'd1);

        // Mid-transaction reset
        rst = 0;
        tick();
        rst = 1;
        i_req = 1; i_addr = 16'h0500;
        #1;
        chk("mr_m_rd0", 16'(m_rd), 16'd1);
        chk("mr_err_cleared", 16'(err), 16'd0);
        tick();
        chk("mr_owner_busy", 16'(owner), 16'd1);
        rst = 0;
        #1;
        chk("mr_owner_rst", 16'(owner), 16'd0);
        chk("mr_m_rd_rst", 16'(m_rd), 16'd0);
        chk("mr_i_done_rst", 16'(i_done), 16'd0);
        tick();
        chk("mr_m_rd_held", 16'(m_rd), 16'd0);
        rst = 1;
        #1;
        chk("mr_regrant_rd", 16'(m_rd), 16'd1);
        chk("mr_regrant_addr", m_addr, 16'h0500);
        m_done = 1; m_rdata = 16'h5A5A;
        #1;
        chk("mr_i_done", 16'(i_done), 16'd1);
        chk("mr_i_data", i_data, 16'h5A5A);
        tick();
        i_req = 0; m_done = 0;

        // m_err alone sets err
        m_err = 1;
        tick();
        m_err = 0;
        #1;
        chk("me_err", 16'(err), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one mem_system instance between the instruction-fetch requester and the data-memory requester in the unified-memory configuration.
- Selects one requester per transaction, drives the memory request, holds it until mem_system reports Done, then routes the response back to the owner.
- Data accesses have priority; a starvation counter bounds fetch latency. A watchdog flags transactions that never complete.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while i_req is pending before fetch is forced to win (1..15).
TIMEOUT, 64, maximum cycles in a busy state without m_done before the transaction is aborted (2..255).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
i_req  in  1  fetch read request; level, held until i_done
i_addr  in  16  fetch address
i_data  out  16  fetch read data, valid when i_done=1
i_done  out  1  fetch transaction complete (1-cycle pulse)
i_stall  out  1  i_req & ~i_done
d_rd  in  1  data read request; level, held until d_done
d_wr  in  1  data write request; level, held until d_done
d_addr  in  16  data address
d_wdata  in  16  data write value
d_rdata  out  16  data read value, valid when d_done=1 and the access was a read
d_done  out  1  data transaction complete (1-cycle pulse)
d_stall  out  1  (d_rd|d_wr) & ~d_done
d_hit  out  1  m_hit forwarded when d_done=1, else 0
m_addr  out  16  to mem_system Addr
m_wdata  out  16  to mem_system DataIn
m_rd  out  1  to mem_system Rd
m_wr  out  1  to mem_system Wr
m_rdata  in  16  from mem_system DataOut
m_done  in  1  from mem_system Done
m_hit  in  1  from mem_system CacheHit
m_err  in  1  from mem_system err
owner  out  2  00 idle, 01 fetch, 10 data
err  out  1  sticky error, cleared only by reset

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Reset (rst=0, async) forces:
  - IDLE, owner=00, starve_cnt=0, wd_cnt=0, err=0.
  - Latched request registers cleared; all m_* and done outputs 0.
- IDLE winner, combinational:
  - Data wins if (d_rd|d_wr) and not (i_req & starve_cnt==STARVE_LIMIT).
  - Otherwise fetch wins if i_req.
  - Otherwise no grant and all m_* outputs are 0.
- IDLE drive: the winner's addr, wdata and rd/wr go straight to m_* in the same cycle.
  - If m_done=1 that cycle (hit): assert the winner's done, stay IDLE.
  - Else: latch winner addr/wdata/rd/wr, go to BUSY_I or BUSY_D next edge.
- BUSY_x:
  - m_* are driven from the latched copy; later changes on requester inputs are ignored.
  - m_done=1 asserts the owner's done, then IDLE next edge. Back-to-back requests therefore cost one IDLE cycle minimum.
- Response routing:
  - i_data = m_rdata when i_done, else 0.
  - d_rdata = m_rdata when d_done, else 0.
  - Non-owner done is always 0.
- starve_cnt, updated at each grant:
  - Data grant with i_req=1: increment, saturating at STARVE_LIMIT.
  - Fetch grant, or data grant with i_req=0: clear to 0.
- Watchdog: wd_cnt counts in BUSY_x and clears in IDLE. On reaching TIMEOUT-1 without m_done:
  - set err;
  - pulse the owner's done with data 0;
  - go to IDLE.
- err is set by: m_err=1 on any cycle; d_rd&d_wr both 1 at grant (the access is then performed as a write); watchdog expiry.
- Simultaneous i_req and data request with no starvation: data is served first; fetch is served in the next transaction.
- Reset mid-transaction: state is abandoned immediately with no done pulse. mem_system shares the same reset.

Test Plan:
- Fetch-only hit: i_req=1, i_addr=16'h0040, m_done=1 same cycle, m_rdata=16'hA5A5 -> i_done=1 and i_data=16'hA5A5 that cycle; owner=00; state stays IDLE.
- Data read miss: d_rd=1, d_addr=16'h1238, m_done after 5 cycles -> m_rd held 5 cycles with m_addr=16'h1238 even if d_addr changes to 0 in cycle 2; d_done pulses once; owner=10 during the wait.
- Contention: i_req and d_wr both held, every access a 3-cycle miss, STARVE_LIMIT=4, d_wr re-asserted immediately each time -> 4 data grants, then 1 fetch grant, then data again.
- Watchdog: d_rd=1, m_done never asserted, TIMEOUT=64 -> d_done pulse at busy cycle 63 with d_rdata=0; err=1 and stays 1; next request is still served.
- Illegal op: d_rd=d_wr=1 -> m_wr=1, m_rd=0, err=1.
- Mid-transaction reset: rst=0 during BUSY_I -> owner=00, m_rd=0 immediately, no i_done; after rst=1, i_req is re-granted from IDLE.
